lsu_mem_bridge: RTL and testbench
=================================

// Module: lsu_mem_bridge
// PURPOSE
//  Load/store unit back end that sits directly upstream of the DPI data-RAM port.
//  Accepts one core load/store request at a time via valid/ready and issues exactly one
//  word-aligned RAM access with the correct byte mask and lane-shifted write data.
//  Aligns and sign- or zero-extends the read word, then returns it on a valid/ready response channel.
// PARAMETERS
//  XLEN        32  data/address width; only 32 is supported.
//  MASK_W      4   byte-mask width, XLEN/8.
// PORTS
//  clock        in   1      single clock; all state updates on posedge.
//  reset        in   1      asynchronous, active-low reset.
//  req_valid    in   1      core request valid.
//  req_ready    out  1      high in IDLE only.
//  req_wen      in   1      1=store, 0=load.
//  req_funct3   in   3      RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
//  req_addr     in   32     byte address.
//  req_wdata    in   32     store data, right-justified.
//  resp_valid   out  1      response valid; held until resp_ready.
//  resp_ready   in   1      core accepts response.
//  resp_rdata   out  32     extended load data; 0 for stores.
//  resp_err     out  1      misaligned access; only driven with LSU_MISALIGN_TRAP_EN.
//  mem_valid    out  1      RAM request strobe, exactly one cycle per access.
//  mem_wen      out  1      RAM write enable (qualified by mem_valid).
//  mem_raddr    out  32     word-aligned read address, {addr[31:2],2'b00}.
//  mem_waddr    out  32     word-aligned write address, same value as mem_raddr.
//  mem_wdata    out  32     store data shifted to byte lane addr[1:0]*8.
//  mem_wmask    out  4      byte mask: SB 4'b0001<<a, SH 4'b0011<<a, SW 4'b1111.
//  mem_rdata    in   32     RAM read word; valid the cycle after the mem_valid edge.
// BEHAVIOUR
//  - FSM states: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
//    IDLE: req_ready=1. On req_valid&&req_ready, latch wen/funct3/addr/wdata and go to ACCESS.
//    ACCESS: mem_valid=1 with registered address/mask/data, then go to WAIT.
//    WAIT: latch the extended mem_rdata into resp_rdata (0 if store), then go to RESP.
//    RESP: resp_valid=1 with stable data until resp_ready is sampled high, then go to IDLE.
//  - Latency: accept edge to resp_valid high is 3 cycles. Best-case throughput is 1 request per 4 cycles.
//  - Extension: LB/LH sign-extend bit 7/15 of the selected lane; LBU/LHU zero-extend; LW passes through.
//  - Lane select for halfwords is addr[1]; for bytes it is addr[1:0].
//  - Reserved funct3 values (011, 110, 111) are treated as word access.
//  - mem_valid, mem_wen and mem_wmask are 0 in every state except ACCESS.
//  - Simultaneous req_valid in RESP is ignored (req_ready=0); no request queue exists.
//  - Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, mem_* outputs 0.
//    req_ready is 1 immediately after reset deasserts.
//  - Reset asserted mid-operation aborts at once: mem_valid drops asynchronously,
//    the pending write is never reissued, and no response is produced.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    - Misaligned accesses are LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//    - A misaligned request goes IDLE -> RESP directly, skipping ACCESS and WAIT.
//    - No mem_valid is issued (no RAM write occurs); resp_err=1 and resp_rdata=0.
//  LSU_MISALIGN_TRAP_EN undefined:
//    - Low address bits beyond the lane select are ignored; words are forced aligned.
//    - resp_err is tied to 0.
// STRUCTURE
//  - Package lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), state enum typedef, XLEN constant.
//  - One natural sub-module, lsu_load_align: combinational (rdata, addr[1:0], funct3) -> extended word.
//  - All FSM, registers and store-lane logic stay in lsu_mem_bridge.
// TESTING
//  1. LW addr 0x80000008, mem_rdata 0xDEADBEEF
//     -> mem_raddr 0x80000008; resp_rdata 0xDEADBEEF; resp_valid 3 cycles after accept.
//  2. LB addr 0x80000003, word 0x80FF1234
//     -> resp_rdata 0xFFFFFF80. LBU at the same address -> 0x00000080.
//  3. SH addr 0x80000012, wdata 0x0000ABCD
//     -> mem_wmask 4'b1100, mem_wdata 0xABCD0000, mem_waddr 0x80000010, resp_rdata 0.
//  4. resp_ready held low 5 cycles in RESP -> resp_valid/resp_rdata stable;
//     req_valid ignored until the handshake completes.
//  5. reset low during ACCESS of SW
//     -> mem_valid 0 in the same cycle; after release: IDLE, req_ready=1, no response.
//  6. (LSU_MISALIGN_TRAP_EN) SW addr 0x80000001
//     -> mem_valid never asserted; resp_err=1, resp_rdata=0, 1 cycle to resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared constants and types for the LSU memory bridge. Holds the
//            data width, the RV32I load/store funct3 encodings, the bridge
//            FSM state type and a helper that maps funct3 to an access size.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int XLEN   = 32;
    localparam int MASK_W = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Reserved encodings (011, 110, 111) fall through to a word access.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_BYTE;
            F3_H, F3_HU: f3_size = SZ_HALF;
            F3_W:        f3_size = SZ_WORD;
            default:     f3_size = SZ_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Purpose  : Combinational load alignment. Selects the byte/halfword lane
//            from a RAM word and sign- or zero-extends it to XLEN bits.
// Ports    : i_rdata   [XLEN-1:0] raw RAM read word
//            i_addr_lo [1:0]      low byte-address bits of the access
//            i_funct3  [2:0]      RV32I load funct3
//            o_data    [XLEN-1:0] aligned, extended load result
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    // funct3[2] distinguishes the unsigned variants (LBU/LHU).
    assign w_signed = ~i_funct3[2];
    assign w_byte   = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (f3_size(i_funct3))
            SZ_BYTE: o_data = {{(XLEN-8){w_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{(XLEN-16){w_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_bridge
// Purpose  : LSU back end in front of the data-RAM port. Accepts one core
//            load/store at a time, issues a single word-aligned RAM access
//            with byte mask and lane-shifted store data, then returns the
//            aligned/extended load word on a valid/ready response channel.
// Config   : LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//            accesses skip the RAM and respond with resp_err=1. When
//            undefined, low address bits are ignored and resp_err is 0.
// Ports    : clock, reset (async, active-low)
//            req_valid/req_ready/req_wen/req_funct3/req_addr/req_wdata
//            resp_valid/resp_ready/resp_rdata/resp_err
//            mem_valid/mem_wen/mem_raddr/mem_waddr/mem_wdata/mem_wmask/mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_bridge
    import lsu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_raddr,
    output logic [XLEN-1:0]   mem_waddr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;

    logic              r_wen;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata_lane;
    logic [MASK_W-1:0] r_wmask;
    logic [XLEN-1:0]   r_resp_rdata;

    logic              w_accept;
    logic              w_misalign;
    lsu_size_t         w_req_size;
    logic [XLEN-1:0]   w_wdata_lane;
    logic [MASK_W-1:0] w_wmask;
    logic [XLEN-1:0]   w_load_ext;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_req_size = f3_size(req_funct3);

    // Store lane steering: unused byte lanes are zeroed so mem_wdata only
    // carries the bytes enabled by the mask.
    always_comb begin
        w_wmask      = '1;
        w_wdata_lane = req_wdata;
        case (w_req_size)
            SZ_BYTE: begin
                w_wmask      = 4'b0001 << req_addr[1:0];
                w_wdata_lane = {24'd0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
            end
            SZ_HALF: begin
                w_wmask      = 4'b0011 << {req_addr[1], 1'b0};
                w_wdata_lane = {16'd0, req_wdata[15:0]} << {req_addr[1], 4'b0000};
            end
            default: begin
                w_wmask      = '1;
                w_wdata_lane = req_wdata;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;

    always_comb begin
        w_misalign = 1'b0;
        case (w_req_size)
            SZ_HALF: w_misalign = req_addr[0];
            SZ_WORD: w_misalign = (req_addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
        end
    end

    assign resp_err = r_err;
`else
    assign w_misalign = 1'b0;
    assign resp_err   = 1'b0;
`endif

    lsu_load_align u_load_align (
        .i_rdata   (mem_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data    (w_load_ext)
    );

    // State register. Because the strobes below decode r_state directly, an
    // asserted reset drops mem_valid immediately and abandons any access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_valid   = 1'b0;
        mem_wen     = 1'b0;
        mem_wmask   = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_misalign ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_valid   = 1'b1;
                mem_wen     = r_wen;
                mem_wmask   = r_wmask;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wen        <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata_lane <= '0;
            r_wmask      <= '0;
            r_resp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_wen        <= req_wen;
                r_funct3     <= req_funct3;
                r_addr       <= req_addr;
                r_wdata_lane <= w_wdata_lane;
                r_wmask      <= w_wmask;
                // A trapped request jumps straight to RESP with zero data.
                if (w_misalign) begin
                    r_resp_rdata <= '0;
                end
            end
            // RAM word is valid here, one cycle after the ACCESS strobe.
            if (r_state == ST_WAIT) begin
                r_resp_rdata <= r_wen ? '0 : w_load_ext;
            end
        end
    end

    assign resp_rdata = r_resp_rdata;
    assign mem_raddr  = {r_addr[XLEN-1:2], 2'b00};
    assign mem_waddr  = {r_addr[XLEN-1:2], 2'b00};
    assign mem_wdata  = r_wdata_lane;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_bridge
// Purpose  : Directed self-checking bench for lsu_mem_bridge. Each scenario
//            task drives one feature and compares against hand-computed
//            expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_bridge;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_bridge dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_wen    (mem_wen),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request, plays the RAM (read word appears after the strobe
    // edge), completes the response handshake and reports what it saw.
    task automatic run_req(
        input  logic        wen,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] rd,
        output int          lat,
        output int          mv_cycles,
        output logic [31:0] o_raddr,
        output logic [31:0] o_waddr,
        output logic [31:0] o_wdata,
        output logic [3:0]  o_wmask,
        output logic        o_wen,
        output logic [31:0] o_rdata,
        output logic        o_err
    );
        logic give;
        give      = 1'b0;
        mv_cycles = 0;
        o_raddr   = '0;
        o_waddr   = '0;
        o_wdata   = '0;
        o_wmask   = '0;
        o_wen     = 1'b0;
        @(negedge clock);
        mem_rdata  = 32'h5A5A_A5A5;
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        lat = 1;
        while (lat < 20) begin
            if (mem_valid) begin
                mv_cycles++;
                o_raddr = mem_raddr;
                o_waddr = mem_waddr;
                o_wdata = mem_wdata;
                o_wmask = mem_wmask;
                o_wen   = mem_wen;
                give    = 1'b1;
            end
            if (resp_valid) break;
            @(posedge clock);
            #1;
            if (give) begin
                mem_rdata = rd;
                give      = 1'b0;
            end
            lat++;
        end
        o_rdata = resp_rdata;
        o_err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_err, mem_valid, mem_wen} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0000", {resp_valid, resp_err, mem_valid, mem_wen});
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp_rdata: got %h want 00000000", resp_rdata);
        end
        checks++;
        if ({mem_raddr, mem_waddr, mem_wdata, mem_wmask} !== 100'd0) begin
            errors++;
            $display("FAIL reset_mem_bus: raddr %h waddr %h wdata %h wmask %b want all 0",
                     mem_raddr, mem_waddr, mem_wdata, mem_wmask);
        end
    endtask

    task automatic test_lw();
        int lat, mv;
        logic [31:0] ra, wa, wd, rdat;
        logic [3:0] wm;
        logic we, er;
        run_req(1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF,
                lat, mv, ra, wa, wd, wm, we, rdat, er);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL lw_latency: got %0d want 3", lat);
        end
        checks++;
        if (mv !== 1) begin
            errors++;
            $display("FAIL lw_mem_valid_cycles: got %0d want 1", mv);
        end
        checks++;
        if (ra !== 32'h8000_0008) begin
            errors++;
            $display("FAIL lw_raddr: got %h want 80000008", ra);
        end
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL lw_mem_wen: got %b want 0", we);
        end
        checks++;
        if (rdat !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lw_rdata: got %h want deadbeef", rdat);
        end
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL lw_err: got %b want 0", er);
        end
    endtask

    task automatic test_load_ext();
        int lat, mv;
        logic [31:0] ra, wa, wd, rdat;
        logic [3:0] wm;
        logic we, er;
        logic [2:0]  f3_v  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b011};
        logic [31:0] adr_v [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002,
                                   32'h8000_0000, 32'h8000_0001, 32'h8000_0004};
        logic [31:0] wrd_v [6] = '{32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234,
                                   32'h80FF_1234, 32'h80FF_1234, 32'h1122_3344};
        logic [31:0] exp_v [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                   32'h0000_1234, 32'h0000_0012, 32'h1122_3344};
        for (int i = 0; i < 6; i++) begin
            run_req(1'b0, f3_v[i], adr_v[i], 32'h0, wrd_v[i],
                    lat, mv, ra, wa, wd, wm, we, rdat, er);
            checks++;
            if (rdat !== exp_v[i]) begin
                errors++;
                $display("FAIL load_ext[%0d] f3=%b addr=%h: got %h want %h",
                         i, f3_v[i], adr_v[i], rdat, exp_v[i]);
            end
        end
        checks++;
        if (ra !== 32'h8000_0004) begin
            errors++;
            $display("FAIL load_ext_raddr: got %h want 80000004", ra);
        end
`ifndef LSU_MISALIGN_TRAP_EN
        run_req(1'b0, 3'b010, 32'h8000_0006, 32'h0, 32'hA1B2_C3D4,
                lat, mv, ra, wa, wd, wm, we, rdat, er);
        checks++;
        if ({ra, rdat} !== {32'h8000_0004, 32'hA1B2_C3D4}) begin
            errors++;
            $display("FAIL lw_force_align: raddr %h rdata %h want 80000004 a1b2c3d4", ra, rdat);
        end
`endif
    endtask

    task automatic test_store();
        int lat, mv;
        logic [31:0] ra, wa, wd, rdat;
        logic [3:0] wm;
        logic we, er;
        run_req(1'b1, 3'b001, 32'h8000_0012, 32'h0000_ABCD, 32'h7777_7777,
                lat, mv, ra, wa, wd, wm, we, rdat, er);
        checks++;
        if (wm !== 4'b1100) begin
            errors++;
            $display("FAIL sh_wmask: got %b want 1100", wm);
        end
        checks++;
        if (wd !== 32'hABCD_0000) begin
            errors++;
            $display("FAIL sh_wdata: got %h want abcd0000", wd);
        end
        checks++;
        if (wa !== 32'h8000_0010) begin
            errors++;
            $display("FAIL sh_waddr: got %h want 80000010", wa);
        end
        checks++;
        if ({we, mv} !== {1'b1, 32'd1}) begin
            errors++;
            $display("FAIL sh_wen: wen %b strobes %0d want 1 and 1", we, mv);
        end
        checks++;
        if (rdat !== 32'h0) begin
            errors++;
            $display("FAIL sh_rdata: got %h want 00000000", rdat);
        end
        run_req(1'b1, 3'b000, 32'h8000_0005, 32'h1234_56A7, 32'h7777_7777,
                lat, mv, ra, wa, wd, wm, we, rdat, er);
        checks++;
        if ({wm, (wd & 32'h0000_FF00)} !== {4'b0010, 32'h0000_A700}) begin
            errors++;
            $display("FAIL sb_lane: wmask %b wdata %h want 0010 and byte1=a7", wm, wd);
        end
        run_req(1'b1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 32'h7777_7777,
                lat, mv, ra, wa, wd, wm, we, rdat, er);
        checks++;
        if ({wm, wd, wa} !== {4'b1111, 32'hCAFE_F00D, 32'h8000_0020}) begin
            errors++;
            $display("FAIL sw_bus: wmask %b wdata %h waddr %h want 1111 cafef00d 80000020", wm, wd, wa);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clock);
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h8000_0100;
        mem_rdata  = 32'h0BAD_F00D;
        @(posedge clock);
        #1;
        n = 0;
        while (!resp_valid && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_reach_resp: resp_valid %b want 1", resp_valid);
        end
        // req_valid stays high throughout RESP; it must be ignored.
        req_addr = 32'h8000_0200;
        repeat (5) begin
            @(posedge clock);
            #1;
            checks++;
            if ({resp_valid, req_ready, mem_valid, resp_rdata} !== {3'b100, 32'h0BAD_F00D}) begin
                errors++;
                $display("FAIL bp_hold: valid %b ready %b mem_valid %b rdata %h want 1 0 0 0badf00d",
                         resp_valid, req_ready, mem_valid, resp_rdata);
            end
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        checks++;
        if ({resp_valid, req_ready, mem_valid} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release: valid %b ready %b mem_valid %b want 0 1 0",
                     resp_valid, req_ready, mem_valid);
        end
    endtask

    task automatic test_reset_abort();
        int bad;
        @(negedge clock);
        req_valid  = 1'b1;
        req_wen    = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h8000_0040;
        req_wdata  = 32'h1357_9BDF;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        checks++;
        if (mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_access: mem_valid %b want 1", mem_valid);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_valid, mem_wen, mem_wmask} !== 6'b0) begin
            errors++;
            $display("FAIL abort_async_drop: mem_valid %b wen %b wmask %b want 0 0 0000",
                     mem_valid, mem_wen, mem_wmask);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        bad = 0;
        repeat (6) begin
            @(posedge clock);
            #1;
            if (mem_valid || resp_valid || !req_ready) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_after_release: %0d bad cycles want 0", bad);
        end
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_misalign();
        int lat, mv;
        logic [31:0] ra, wa, wd, rdat;
        logic [3:0] wm;
        logic we, er;
        run_req(1'b1, 3'b010, 32'h8000_0001, 32'h1234_5678, 32'h7777_7777,
                lat, mv, ra, wa, wd, wm, we, rdat, er);
        checks++;
        if ({lat, mv} !== {32'd1, 32'd0}) begin
            errors++;
            $display("FAIL trap_sw_timing: latency %0d strobes %0d want 1 and 0", lat, mv);
        end
        checks++;
        if ({er, rdat} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL trap_sw_resp: err %b rdata %h want 1 00000000", er, rdat);
        end
        run_req(1'b0, 3'b001, 32'h8000_0003, 32'h0, 32'h7777_7777,
                lat, mv, ra, wa, wd, wm, we, rdat, er);
        checks++;
        if ({er, mv} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL trap_lh: err %b strobes %0d want 1 and 0", er, mv);
        end
        run_req(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234,
                lat, mv, ra, wa, wd, wm, we, rdat, er);
        checks++;
        if ({er, rdat, lat} !== {1'b0, 32'hFFFF_FF80, 32'd3}) begin
            errors++;
            $display("FAIL trap_lb_ok: err %b rdata %h latency %0d want 0 ffffff80 3", er, rdat, lat);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_backpressure();
        test_reset_abort();
`ifdef LSU_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
